// File: rtl/prt_lb_arb_if.sv
// prt_dp_lb_if: single-port local-bus connection (master side drives lb_out).
//   adr   word address, P_ADR_WIDTH bits
//   wr/rd one-cycle write / read strobes
//   din   write data (master to slave)
//   dout  read data (slave to master)
//   vld   one-cycle read-data strobe from the slave
interface prt_dp_lb_if #(
  parameter int unsigned P_ADR_WIDTH = 16
) ();
  logic [P_ADR_WIDTH-1:0] adr;
  logic                   wr;
  logic                   rd;
  logic [31:0]            din;
  logic [31:0]            dout;
  logic                   vld;

  modport lb_out (output adr, wr, rd, din, input dout, vld);
  modport lb_in  (input adr, wr, rd, din, output dout, vld);
endinterface

// File: rtl/prt_lb_arb.sv
// prt_lb_arb: two-master local-bus arbiter with one outstanding transaction and
// round-robin fairness between master 0 and master 1.
//
// Ports:
//   CLK_IN, RST_IN                 clock, synchronous active-high reset
//   Mx_ADR_IN / Mx_DAT_IN          request address / write data
//   Mx_WR_IN / Mx_RD_IN            level requests, held until RDY (WR wins over RD)
//   Mx_RDY_OUT                     request accepted this cycle (combinational)
//   Mx_DAT_OUT / Mx_VLD_OUT        read data and its one-cycle strobe
//   LB_DWN_IF                      downstream bus (prt_dp_lb_if.lb_out)
//   STA_TMO_OUT                    sticky read-timeout flag
//
// Build option: define PRT_LB_ARB_TIMEOUT_EN to compile in the read timeout.
// Without it a read waits for the slave indefinitely and STA_TMO_OUT is 0.
module prt_lb_arb #(
  parameter int unsigned P_ADR_WIDTH  = 16,
  parameter int unsigned P_TMO_CYCLES = 1024,
  parameter logic [31:0] P_TMO_DAT    = 32'hDEAD_DEAD
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic [P_ADR_WIDTH-1:0] M0_ADR_IN,
  input  logic                   M0_WR_IN,
  input  logic                   M0_RD_IN,
  input  logic [31:0]            M0_DAT_IN,
  output logic                   M0_RDY_OUT,
  output logic [31:0]            M0_DAT_OUT,
  output logic                   M0_VLD_OUT,
  input  logic [P_ADR_WIDTH-1:0] M1_ADR_IN,
  input  logic                   M1_WR_IN,
  input  logic                   M1_RD_IN,
  input  logic [31:0]            M1_DAT_IN,
  output logic                   M1_RDY_OUT,
  output logic [31:0]            M1_DAT_OUT,
  output logic                   M1_VLD_OUT,
  prt_dp_lb_if.lb_out            LB_DWN_IF,
  output logic                   STA_TMO_OUT
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

  state_e state_q, state_d;

  logic                   req0, req1;
  logic                   gnt0, gnt1;
  logic                   accept;
  logic                   last_q;   // 1: M1 was served last
  logic [P_ADR_WIDTH-1:0] adr_q;
  logic [31:0]            din_q;
  logic                   op_wr_q;
  logic                   own_q;    // owner of the current transaction (1 = M1)
  logic [31:0]            dat0_q, dat1_q;
  logic                   vld0_q, vld1_q;
  logic                   tmo_hit;
  logic                   rd_done;
  logic [31:0]            rd_dat;

  assign req0 = M0_WR_IN | M0_RD_IN;
  assign req1 = M1_WR_IN | M1_RD_IN;

  // On a tie the master not served last wins.
  assign gnt0 = req0 & (~req1 | last_q);
  assign gnt1 = req1 & (~req0 | ~last_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (gnt0 | gnt1) state_d = StIssue;
      StIssue:  state_d = op_wr_q ? StIdle : StWaitRd;
      StWaitRd: if (rd_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (gated by reset so nothing is granted or strobed meanwhile)
  // ---------------------------------------------------------------------------
  always_comb begin
    M0_RDY_OUT   = 1'b0;
    M1_RDY_OUT   = 1'b0;
    LB_DWN_IF.wr = 1'b0;
    LB_DWN_IF.rd = 1'b0;
    if (!RST_IN) begin
      unique case (state_q)
        StIdle: begin
          M0_RDY_OUT = gnt0;
          M1_RDY_OUT = gnt1;
        end
        StIssue: begin
          LB_DWN_IF.wr = op_wr_q;
          LB_DWN_IF.rd = ~op_wr_q;
        end
        default: ;
      endcase
    end
  end

  assign accept = M0_RDY_OUT | M1_RDY_OUT;

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      op_wr_q <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
    end else if (accept) begin
      last_q  <= M1_RDY_OUT;
      own_q   <= M1_RDY_OUT;
      // WR and RD together is a write.
      op_wr_q <= M1_RDY_OUT ? M1_WR_IN  : M0_WR_IN;
      adr_q   <= M1_RDY_OUT ? M1_ADR_IN : M0_ADR_IN;
      din_q   <= M1_RDY_OUT ? M1_DAT_IN : M0_DAT_IN;
    end
  end

  assign LB_DWN_IF.adr = adr_q;
  assign LB_DWN_IF.din = din_q;

  // ---------------------------------------------------------------------------
  // Read timeout
  // ---------------------------------------------------------------------------
`ifdef PRT_LB_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (P_TMO_CYCLES > 1) ? $clog2(P_TMO_CYCLES) : 1;

  logic [TmoW-1:0] tmo_cnt_q;
  logic            sta_tmo_q;

  assign tmo_hit = (tmo_cnt_q == TmoW'(P_TMO_CYCLES - 1));

  // Counts cycles spent in WAIT_RD; zero on entry.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || (state_q != StWaitRd)) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      sta_tmo_q <= 1'b0;
    end else if ((state_q == StWaitRd) && tmo_hit && !LB_DWN_IF.vld) begin
      sta_tmo_q <= 1'b1;
    end
  end

  assign STA_TMO_OUT = sta_tmo_q;
  // A real answer arriving on the timeout cycle takes priority.
  assign rd_dat      = LB_DWN_IF.vld ? LB_DWN_IF.dout : P_TMO_DAT;
`else
  logic unused_tmo;

  assign unused_tmo  = ^{P_TMO_DAT, P_TMO_CYCLES};
  assign tmo_hit     = 1'b0;
  assign STA_TMO_OUT = 1'b0;
  assign rd_dat      = LB_DWN_IF.dout;
`endif

  // ---------------------------------------------------------------------------
  // Read return; vld outside WAIT_RD is ignored
  // ---------------------------------------------------------------------------
  assign rd_done = (state_q == StWaitRd) & (LB_DWN_IF.vld | tmo_hit);

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      dat0_q <= '0;
      dat1_q <= '0;
    end else begin
      vld0_q <= rd_done & ~own_q;
      vld1_q <= rd_done & own_q;
      if (rd_done && !own_q) dat0_q <= rd_dat;
      if (rd_done && own_q)  dat1_q <= rd_dat;
    end
  end

  assign M0_VLD_OUT = vld0_q;
  assign M1_VLD_OUT = vld1_q;
  assign M0_DAT_OUT = dat0_q;
  assign M1_DAT_OUT = dat1_q;

endmodule
